// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// Module   : hazard_stall_ctrl
// Summary  : Pipeline sequencer for load-use stalls, branch flushes and data-memory
//            handshake. Optional macro STALL_CNT_EN enables the stall counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IFID_Rs,
    input  logic [4:0]       IFID_Rt,
    input  logic [4:0]       IDEX_Rt,
    input  logic             IDEX_MemRead,
    input  logic             BranchTaken,
    input  logic             MemReadMEM,
    input  logic             MemWriteMEM,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXWrite,
    output logic             IDEXFlush,
    output logic             EXMEMWrite,
    output logic             MEMWBFlush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t     r_state, w_next_state;
    logic [7:0] r_wait_cnt, w_next_wait_cnt;
    logic       r_mem_err, w_next_mem_err;
    logic       w_acc, w_lu, w_freeze;

    assign w_acc = MemReadMEM | MemWriteMEM;
    assign w_lu  = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                   ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait_cnt;
            r_mem_err  <= w_next_mem_err;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_wait_cnt = r_wait_cnt;
        w_next_mem_err  = r_mem_err;
        w_freeze        = 1'b0;
        mem_req         = 1'b0;
        PCWrite         = 1'b1;
        IFIDWrite       = 1'b1;
        IFIDFlush       = 1'b0;
        IDEXWrite       = 1'b1;
        IDEXFlush       = 1'b0;
        EXMEMWrite      = 1'b1;
        MEMWBFlush      = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_acc) begin
                    mem_req = 1'b1;
                    if (!mem_ready) begin
                        w_freeze        = 1'b1;
                        w_next_state    = ST_WAIT;
                        w_next_wait_cnt = 8'd1;
                    end
                end
            end
            ST_WAIT: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    w_next_state    = ST_RUN;
                    w_next_wait_cnt = 8'd0;
                end else begin
                    w_freeze = 1'b1;
                    if (r_wait_cnt == c_max_wait) begin
                        w_next_state   = ST_ERR;
                        w_next_mem_err = 1'b1;
                    end else begin
                        w_next_wait_cnt = r_wait_cnt + 8'd1;
                    end
                end
            end
            ST_ERR: begin
                w_freeze = 1'b1;
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase

        // A frozen pipeline keeps its registers, so hazards simply re-resolve on release.
        if (w_freeze) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            EXMEMWrite = 1'b0;
            MEMWBFlush = 1'b1;
        end else if (w_lu) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
        end else if (BranchTaken) begin
            IFIDFlush = 1'b1;
        end
    end

    assign mem_err = r_mem_err;

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (!PCWrite && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Summary  : Scoreboard bench for hazard_stall_ctrl with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_ctrl;

    localparam int CNT_W = 16;

    // Output patterns: {mem_req, PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, EXMEMWrite, MEMWBFlush}
    localparam logic [7:0] P_NORM = 8'b0_1_1_0_1_0_1_0;
    localparam logic [7:0] P_LU   = 8'b0_0_0_0_1_1_1_0;
    localparam logic [7:0] P_BR   = 8'b0_1_1_1_1_0_1_0;
    localparam logic [7:0] P_FRZ  = 8'b1_0_0_0_0_0_0_1;
    localparam logic [7:0] P_ZW   = 8'b1_1_1_0_1_0_1_0;
    localparam logic [7:0] P_ERR  = 8'b0_0_0_0_0_0_0_1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       IFID_Rs, IFID_Rt, IDEX_Rt;
    logic             IDEX_MemRead, BranchTaken, MemReadMEM, MemWriteMEM, mem_ready;
    logic             mem_req, PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush;
    logic             EXMEMWrite, MEMWBFlush, mem_err;
    logic [CNT_W-1:0] stall_cnt;

    hazard_stall_ctrl #(.MAX_WAIT(4), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .IFID_Rs      (IFID_Rs),
        .IFID_Rt      (IFID_Rt),
        .IDEX_Rt      (IDEX_Rt),
        .IDEX_MemRead (IDEX_MemRead),
        .BranchTaken  (BranchTaken),
        .MemReadMEM   (MemReadMEM),
        .MemWriteMEM  (MemWriteMEM),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .PCWrite      (PCWrite),
        .IFIDWrite    (IFIDWrite),
        .IFIDFlush    (IFIDFlush),
        .IDEXWrite    (IDEXWrite),
        .IDEXFlush    (IDEXFlush),
        .EXMEMWrite   (EXMEMWrite),
        .MEMWBFlush   (MEMWBFlush),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    logic [24:0] exp_q[$];
    int          id_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          vec_id   = 0;
    int          sc_model = 0;

    // Inputs change 1 time unit after the rising edge; the expected response for that
    // cycle is queued and checked by the monitor at the following falling edge.
    task automatic vec(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] idrt,
                       input logic idmr, input logic br, input logic mr, input logic mw,
                       input logic rdy, input logic rst, input logic [7:0] pat,
                       input logic err);
        logic [CNT_W-1:0] cexp;
        @(posedge clk);
        #1;
        IFID_Rs      = rs;
        IFID_Rt      = rt;
        IDEX_Rt      = idrt;
        IDEX_MemRead = idmr;
        BranchTaken  = br;
        MemReadMEM   = mr;
        MemWriteMEM  = mw;
        mem_ready    = rdy;
        reset        = rst;
        if (!rst) sc_model = 0;
`ifdef STALL_CNT_EN
        cexp = CNT_W'(sc_model);
        if (rst && !pat[6]) sc_model++;
`else
        cexp = '0;
`endif
        exp_q.push_back({pat, err, cexp});
        id_q.push_back(vec_id);
        vec_id++;
    endtask

    initial begin : monitor
        logic [24:0] act, expv;
        int          id;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                expv = exp_q.pop_front();
                id   = id_q.pop_front();
                act  = {mem_req, PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush,
                        EXMEMWrite, MEMWBFlush, mem_err, stall_cnt};
                n_checks++;
                if (act !== expv) begin
                    n_fail++;
                    $display("FAIL vec%0d: got %07h expected %07h", id, act, expv);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset = 1'b0;
        {IFID_Rs, IFID_Rt, IDEX_Rt} = '0;
        {IDEX_MemRead, BranchTaken, MemReadMEM, MemWriteMEM, mem_ready} = '0;

        //   rs     rt     idrt  mr br mR mW rdy rst pattern err
        vec(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, P_NORM, 0); // reset held
        vec(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, P_NORM, 0); // release
        vec(5'd5, 5'd0, 5'd5, 1, 0, 0, 0, 0, 1, P_LU,   0); // load-use via Rs
        vec(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, P_NORM, 0); // stall lasts one cycle
        vec(5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 1, P_NORM, 0); // Rt==0 never stalls
        vec(5'd3, 5'd7, 5'd7, 1, 0, 0, 0, 0, 1, P_LU,   0); // load-use via Rt
        vec(5'd3, 5'd7, 5'd7, 0, 0, 0, 0, 0, 1, P_NORM, 0); // not a load
        vec(5'd9, 5'd2, 5'd9, 1, 1, 0, 0, 0, 1, P_LU,   0); // lu beats branch
        vec(5'd9, 5'd2, 5'd9, 0, 1, 0, 0, 0, 1, P_BR,   0); // branch re-resolves
        vec(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1, P_NORM, 0); // ready without access
        vec(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, 1, P_ZW,   0); // zero-wait access
        vec(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 1, P_FRZ,  0); // wait cycle 1
        vec(5'd4, 5'd0, 5'd4, 1, 1, 1, 0, 0, 1, P_FRZ,  0); // wait 2, lu+branch masked
        vec(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 1, P_FRZ,  0); // wait 3
        vec(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, 1, P_ZW,   0); // ready, release
        vec(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, P_NORM, 0); // back in RUN
        vec(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 1, P_FRZ,  0); // timeout: edge 1 -> WAIT
        vec(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 1, P_FRZ,  0);
        vec(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 1, P_FRZ,  0);
        vec(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 1, P_FRZ,  0);
        vec(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 1, P_FRZ,  0); // edge 5 -> ERR
        vec(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 1, P_ERR,  1);
        vec(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1, P_ERR,  1); // ERR ignores ready
        vec(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, P_NORM, 0); // reset pulse
        vec(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, P_NORM, 0);
        vec(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 1, P_FRZ,  0); // enter WAIT
        vec(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 1, P_FRZ,  0);
        vec(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, P_NORM, 0); // async reset mid-WAIT
        vec(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, P_NORM, 0);

        repeat (3) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
